// File: rtl/hex_scan_display_if.sv
// Load/display bundle between value producer and hex_scan_display.
// Ports: value/dp/load/blank/bright in; busy/frame/seg/dp/an out.
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    load_i;
    logic                    busy_o;
    logic                    blank_zeros_i;
    logic [3:0]              bright_i;
    logic                    frame_o;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;

    modport master (
        output value_i, dp_i, load_i, blank_zeros_i, bright_i,
        input  busy_o, frame_o, seg_o, dp_o, an_o
    );

    modport slave (
        input  value_i, dp_i, load_i, blank_zeros_i, bright_i,
        output busy_o, frame_o, seg_o, dp_o, an_o
    );
endinterface

// File: rtl/hex_scan_display.sv
// Multiplexed 7-seg hex scanner: PWM, zero blanking, frame-synced load.
// Ports: clk, rst (async high), bus (slave modport of hex_scan_display_if).
module hex_scan_display #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000
) (
    input  logic               clk,
    input  logic               rst,
    hex_scan_display_if.slave  bus
);
    localparam int PW = $clog2(DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0]      shadow_dp;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [NUM_DIGITS-1:0]      disp_dp;
    logic                       busy;
    logic                       frame;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic                  wrap;
    logic                  boundary;
    logic [28:0]           on_lim;
    logic                  on_win;
    logic [NUM_DIGITS-1:0] zero_run;
    logic                  run;
    logic                  blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign wrap     = (presc == P_LAST);
    assign boundary = wrap && (idx == I_LAST);

    // 29 bits hold (16 * 2^24) so the product never overflows.
    assign on_lim = ((29'(bus.bright_i) + 29'd1) * 29'(DIV)) >> 4;
    assign on_win = 29'(presc) < on_lim;

    // zero_run[i]: digits NUM_DIGITS-1..i are all "0" with no dp.
    always_comb begin
        zero_run = '0;
        run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run         = run & (disp[i] == 4'h0) & ~disp_dp[i];
            zero_run[i] = run;
        end
    end

    assign blank = bus.blank_zeros_i && (idx != '0) && zero_run[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (wrap) begin
            presc <= '0;
            idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load on the boundary edge lands in shadow while the older
    // shadow commits, so busy stays set for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            disp      <= '0;
            disp_dp   <= '0;
            busy      <= 1'b0;
            frame     <= 1'b0;
        end else begin
            frame <= boundary;
            if (boundary && busy) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
                busy    <= 1'b0;
            end
            if (bus.load_i) begin
                shadow    <= bus.value_i;
                shadow_dp <= bus.dp_i;
                busy      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else if (on_win && !blank) begin
            seg_q <= hex7(disp[idx]);
            dp_q  <= ~disp_dp[idx];
            an_q  <= ~(NUM_DIGITS'(1) << idx);
        end else begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end
    end

    assign bus.busy_o  = busy;
    assign bus.frame_o = frame;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.an_o    = an_q;
endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display at NUM_DIGITS=4, DIV=16.
// Ports: none; drives the bus master side and checks outputs.
module tb_hex_scan_display;
    localparam int ND = 4;
    localparam int DV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    hex_scan_display_if #(.NUM_DIGITS(ND)) bus ();

    hex_scan_display #(
        .NUM_DIGITS(ND),
        .DIV(DV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (bus.frame_o !== 1'b1 && cnt < 200);
        if (bus.frame_o !== 1'b1) check("frame_timeout", bus.frame_o, 1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        bus.value_i = v;
        bus.dp_i    = d;
        bus.load_i  = 1'b1;
        step(1);
        bus.load_i  = 1'b0;
    endtask

    // Called on a frame_o negedge; samples 3 cycles into each slot.
    task automatic scan_check(input string tag,
                              input logic [3:0][6:0] es,
                              input logic [3:0][3:0] ea,
                              input logic [3:0] edp);
        step(3);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_an%0d", tag, d), bus.an_o, ea[d]);
            check($sformatf("%s_seg%0d", tag, d), bus.seg_o, es[d]);
            check($sformatf("%s_dp%0d", tag, d), bus.dp_o, edp[d]);
            if (d < ND - 1) step(16);
        end
    endtask

    initial begin
        int c;
        logic fr;
        logic [3:0] br_tab[3];
        int         on_tab[3];
        int         on_cnt;

        bus.value_i       = '0;
        bus.dp_i          = '0;
        bus.load_i        = 1'b0;
        bus.blank_zeros_i = 1'b0;
        bus.bright_i      = 4'hF;

        step(2);
        check("rst_seg", bus.seg_o, 7'h7F);
        check("rst_dp", bus.dp_o, 1);
        check("rst_an", bus.an_o, 4'hF);
        check("rst_busy", bus.busy_o, 0);
        check("rst_frame", bus.frame_o, 0);

        rst = 1'b0;
        step(5);
        check("run_an", bus.an_o, 4'hE);
        check("run_seg", bus.seg_o, 7'h40);

        #2 rst = 1'b1;
        #1;
        check("mid_rst_seg", bus.seg_o, 7'h7F);
        check("mid_rst_dp", bus.dp_o, 1);
        check("mid_rst_an", bus.an_o, 4'hF);
        @(negedge clk);
        rst = 1'b0;

        step(1);
        check("idx0_after_rst", bus.an_o, 4'hE);
        fr = 1'b0;
        repeat (62) begin
            step(1);
            fr |= bus.frame_o;
        end
        check("no_early_frame", fr, 0);
        step(1);
        check("first_frame", bus.frame_o, 1);

        load(16'h1234, 4'h0);
        check("busy_set", bus.busy_o, 1);
        wait_frame(c);
        check("commit_wait", c, 63);
        check("busy_clr", bus.busy_o, 0);
        scan_check("v1234", {7'h79, 7'h24, 7'h30, 7'h19},
                   {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

        wait_frame(c);
        load(16'hAAAA, 4'h0);
        load(16'h5555, 4'h0);
        check("busy_2loads", bus.busy_o, 1);
        check("old_held", bus.seg_o, 7'h19);
        wait_frame(c);
        scan_check("v5555", {7'h12, 7'h12, 7'h12, 7'h12},
                   {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

        wait_frame(c);
        load(16'hBEEF, 4'h0);
        step(62);
        bus.value_i = 16'h9876;
        bus.load_i  = 1'b1;
        step(1);
        bus.load_i  = 1'b0;
        check("bnd_frame", bus.frame_o, 1);
        check("bnd_busy", bus.busy_o, 1);
        scan_check("vBEEF", {7'h03, 7'h06, 7'h06, 7'h0E},
                   {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);
        wait_frame(c);
        check("bnd_busy_clr", bus.busy_o, 0);
        scan_check("v9876", {7'h10, 7'h00, 7'h78, 7'h02},
                   {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

        wait_frame(c);
        wait_frame(c);
        check("frame_period", c, 64);

        bus.blank_zeros_i = 1'b1;
        load(16'h0030, 4'h0);
        wait_frame(c);
        scan_check("blank", {7'h7F, 7'h7F, 7'h30, 7'h40},
                   {4'hF, 4'hF, 4'hD, 4'hE}, 4'hF);
        wait_frame(c);
        load(16'h0030, 4'h8);
        wait_frame(c);
        scan_check("blank_dp", {7'h40, 7'h40, 7'h30, 7'h40},
                   {4'h7, 4'hB, 4'hD, 4'hE}, 4'h7);

        br_tab = '{4'd0, 4'd7, 4'd15};
        on_tab = '{1, 8, 16};
        for (int b = 0; b < 3; b++) begin
            wait_frame(c);
            bus.bright_i = br_tab[b];
            on_cnt = 0;
            repeat (16) begin
                step(1);
                if (bus.an_o != 4'hF) on_cnt++;
            end
            check($sformatf("bright%0d", br_tab[b]), on_cnt, on_tab[b]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
